fb_write_arbiter: RTL and testbench

Shares the single write port of the frame-buffer dual-port RAM between two game-logic requesters (player A, player B) and an internal screen-clear engine. It sits between the game FSM and the RAM write side and runs on the game clock. It issues at most one RAM write per cycle, round-robin fair between requesters, with a req/gnt handshake. A clear command floods the whole visible buffer with one colour.

---
 rtl/fb_write_arbiter_if.sv | 48 ++++
 rtl/fb_write_arbiter.sv | 161 ++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_write_arbiter_if.sv
// fb_write_arbiter_if
// Bundles the frame-buffer write-arbiter handshake and RAM write bus.
//   Requester A/B : req_x, addr_x, data_x (to arbiter), gnt_x (from arbiter)
//   Clear engine  : clr_start, clr_color (to arbiter), clr_busy, clr_done (from arbiter)
//   Status        : err_oob (from arbiter)
//   RAM write     : mem_addr, mem_data, mem_we (from arbiter)
// The master modport is the game-logic side; the slave modport is the arbiter.
interface fb_write_arbiter_if #(
  parameter int AW = 15,
  parameter int DW = 3
);
  logic          req_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] data_a;
  logic          gnt_a;

  logic          req_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] data_b;
  logic          gnt_b;

  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  logic          clr_done;

  logic          err_oob;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we;

  modport master (
    output req_a, addr_a, data_a,
    output req_b, addr_b, data_b,
    output clr_start, clr_color,
    input  gnt_a, gnt_b, clr_busy, clr_done, err_oob,
    input  mem_addr, mem_data, mem_we
  );

  modport slave (
    input  req_a, addr_a, data_a,
    input  req_b, addr_b, data_b,
    input  clr_start, clr_color,
    output gnt_a, gnt_b, clr_busy, clr_done, err_oob,
    output mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
// Shares the single write port of the frame-buffer RAM between two game-logic
// requesters (A, B) and an internal screen-clear engine. At most one RAM write
// per cycle, round-robin between A and B, every output registered.
// Ports:
//   clk  - game clock, rising edge
//   rst  - synchronous active-low reset
//   bus  - fb_write_arbiter_if.slave: requester handshakes, clear control,
//          err_oob status and the RAM write bus (mem_addr/mem_data/mem_we)
module fb_write_arbiter #(
  parameter int AW          = 15,
  parameter int DW          = 3,
  parameter int CLEAR_WORDS = 21120
) (
  input logic               clk,
  input logic               rst,
  fb_write_arbiter_if.slave bus
);

  typedef enum logic {
    ARB,
    CLEAR
  } state_t;

  // One extra bit so CLEAR_WORDS == 2^AW still compares correctly.
  localparam logic [AW:0]   CLR_LIMIT = (AW+1)'(CLEAR_WORDS);
  localparam logic [AW-1:0] CNT_LAST  = AW'(CLEAR_WORDS - 1);

  state_t        state_q, state_d;
  logic          lastB_q, lastB_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] color_q, color_d;

  logic          gntA_q, gntA_d;
  logic          gntB_q, gntB_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  logic          eligA, eligB, winB;
  logic [AW-1:0] winAddr;
  logic [DW-1:0] winData;

  // A requester granted last cycle is masked so a held req does not get a
  // second grant while it is being withdrawn. On a tie the requester that did
  // not win last time goes first.
  always_comb begin
    eligA   = bus.req_a & ~gntA_q;
    eligB   = bus.req_b & ~gntB_q;
    winB    = eligB & (~eligA | ~lastB_q);
    winAddr = winB ? bus.addr_b : bus.addr_a;
    winData = winB ? bus.data_b : bus.data_a;
  end

  // Next-state and registered-output logic. The first clear write (address 0)
  // is issued on the same edge that accepts clr_start, so while clearing the
  // counter always equals the address currently on mem_addr.
  always_comb begin
    state_d = state_q;
    lastB_d = lastB_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    gntA_d  = 1'b0;
    gntB_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    case (state_q)
      ARB: begin
        if (bus.clr_start) begin
          state_d = CLEAR;
          color_d = bus.clr_color;
          cnt_d   = '0;
          busy_d  = 1'b1;
          we_d    = 1'b1;
          addr_d  = '0;
          data_d  = bus.clr_color;
        end else if (eligA | eligB) begin
          gntA_d  = ~winB;
          gntB_d  = winB;
          lastB_d = winB;
          addr_d  = winAddr;
          data_d  = winData;
          // Out-of-range writes are dropped but still granted so the
          // requester is not left waiting forever.
          if ({1'b0, winAddr} < CLR_LIMIT) begin
            we_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ARB;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          busy_d = 1'b1;
          we_d   = 1'b1;
          addr_d = cnt_q + 1'b1;
          data_d = color_q;
        end
      end

      default: begin
        state_d = ARB;
      end
    endcase
  end

  // State and output registers; reset returns to arbitration with the
  // last-winner pointer on B so A wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARB;
      lastB_q <= 1'b1;
      cnt_q   <= '0;
      color_q <= '0;
      gntA_q  <= 1'b0;
      gntB_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      lastB_q <= lastB_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
      gntA_q  <= gntA_d;
      gntB_q  <= gntB_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign bus.gnt_a    = gntA_q;
  assign bus.gnt_b    = gntB_q;
  assign bus.clr_busy = busy_q;
  assign bus.clr_done = done_q;
  assign bus.err_oob  = err_q;
  assign bus.mem_we   = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_data = data_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter
// Scoreboard bench for fb_write_arbiter. A reference model samples inputs at
// each rising edge and queues the response expected in the following cycle;
// a monitor compares on each falling edge whenever the DUT shows activity.
module tb_fb_write_arbiter;
  localparam int AW = 15;
  localparam int DW = 3;
  localparam int CW = 21120;

  typedef struct {
    int            cyc;
    bit            gA;
    bit            gB;
    bit            we;
    bit            err;
    bit            done;
    bit            busy;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  fb_write_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  fb_write_arbiter #(.AW(AW), .DW(DW), .CLEAR_WORDS(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  exp_t expQ[$];
  int   cyc            = 0;
  int   checks         = 0;
  int   errors         = 0;
  int   zeroCheckCyc   = -1;
  bit   timeoutSeen    = 1'b0;
  bit   timeoutCounted = 1'b0;

  // Reference model state, in terms of the behaviour rather than the RTL.
  int            clrPos = -1;
  bit            lastB  = 1'b1;
  bit            pgA    = 1'b0;
  bit            pgB    = 1'b0;
  logic [DW-1:0] mColor = '0;
  logic [AW-1:0] mAddr  = '0;
  logic [DW-1:0] mData  = '0;

  task automatic pushExp(input bit gA, input bit gB, input bit we, input bit err,
                         input bit done, input bit busy);
    exp_t e;
    e.cyc  = cyc;
    e.gA   = gA;
    e.gB   = gB;
    e.we   = we;
    e.err  = err;
    e.done = done;
    e.busy = busy;
    e.addr = mAddr;
    e.data = mData;
    expQ.push_back(e);
  endtask

  // Reference model: what should appear on the outputs after this edge.
  initial begin
    bit eA, eB, pickB, oob;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        clrPos = -1;
        lastB  = 1'b1;
        pgA    = 1'b0;
        pgB    = 1'b0;
        mColor = '0;
        mAddr  = '0;
        mData  = '0;
      end else if (clrPos >= 0) begin
        pgA = 1'b0;
        pgB = 1'b0;
        if (clrPos == CW - 1) begin
          clrPos = -1;
          pushExp(0, 0, 0, 0, 1, 0);
        end else begin
          clrPos++;
          mAddr = AW'(clrPos);
          mData = mColor;
          pushExp(0, 0, 1, 0, 0, 1);
        end
      end else if (bus.clr_start) begin
        mColor = bus.clr_color;
        clrPos = 0;
        mAddr  = '0;
        mData  = mColor;
        pgA    = 1'b0;
        pgB    = 1'b0;
        pushExp(0, 0, 1, 0, 0, 1);
      end else begin
        eA = bus.req_a && !pgA;
        eB = bus.req_b && !pgB;
        if (eA || eB) begin
          pickB = (eA && eB) ? !lastB : eB;
          lastB = pickB;
          pgA   = !pickB;
          pgB   = pickB;
          mAddr = pickB ? bus.addr_b : bus.addr_a;
          mData = pickB ? bus.data_b : bus.data_a;
          oob   = int'(mAddr) >= CW;
          pushExp(!pickB, pickB, !oob, oob, 0, 0);
        end else begin
          pgA = 1'b0;
          pgB = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput();
    exp_t e;
    bit   evt;
    if (cyc == zeroCheckCyc) begin
      checks++;
      if ({bus.gnt_a, bus.gnt_b, bus.clr_busy, bus.clr_done, bus.err_oob, bus.mem_we,
           bus.mem_addr, bus.mem_data} != '0) begin
        errors++;
        $display("[TB] FAIL reset_outputs cyc=%0d got gA=%0b gB=%0b busy=%0b done=%0b err=%0b we=%0b addr=%0d data=%0d want all 0",
                 cyc, bus.gnt_a, bus.gnt_b, bus.clr_busy, bus.clr_done, bus.err_oob,
                 bus.mem_we, bus.mem_addr, bus.mem_data);
      end
    end
    if (timeoutSeen && !timeoutCounted) begin
      timeoutCounted = 1'b1;
      checks++;
      errors++;
      $display("[TB] FAIL wait_timeout cyc=%0d got no expected DUT event want event within bound", cyc);
    end
    evt = bus.gnt_a | bus.gnt_b | bus.mem_we | bus.err_oob | bus.clr_done;
    if (expQ.size() != 0 && expQ[0].cyc == cyc) begin
      e = expQ.pop_front();
      checks++;
      if (bus.gnt_a !== e.gA || bus.gnt_b !== e.gB || bus.mem_we !== e.we ||
          bus.err_oob !== e.err || bus.clr_done !== e.done || bus.clr_busy !== e.busy ||
          bus.mem_addr !== e.addr || bus.mem_data !== e.data) begin
        errors++;
        $display("[TB] FAIL scoreboard cyc=%0d got gA=%0b gB=%0b we=%0b err=%0b done=%0b busy=%0b addr=%0d data=%0d want gA=%0b gB=%0b we=%0b err=%0b done=%0b busy=%0b addr=%0d data=%0d",
                 cyc, bus.gnt_a, bus.gnt_b, bus.mem_we, bus.err_oob, bus.clr_done,
                 bus.clr_busy, bus.mem_addr, bus.mem_data, e.gA, e.gB, e.we, e.err,
                 e.done, e.busy, e.addr, e.data);
      end
    end else if (evt || bus.clr_busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_event cyc=%0d got gA=%0b gB=%0b we=%0b err=%0b done=%0b busy=%0b want no activity",
               cyc, bus.gnt_a, bus.gnt_b, bus.mem_we, bus.err_oob, bus.clr_done, bus.clr_busy);
    end
  endtask

  // Monitor: decoupled from stimulus, compares whenever a cycle is due.
  initial forever begin
    @(negedge clk);
    checkOutput();
  end

  function automatic logic [AW-1:0] randAddr();
    if ($urandom_range(0, 7) == 0) return AW'($urandom_range(CW, (1 << AW) - 1));
    return AW'($urandom_range(0, CW - 1));
  endfunction

  // Requester agents: keep req/addr/data stable until the grant is seen, then
  // drop the request or present a new one.
  task automatic applyStimulus();
    if (bus.gnt_a) begin
      if ($urandom_range(0, 2) == 0) bus.req_a = 1'b0;
      else begin
        bus.addr_a = randAddr();
        bus.data_a = DW'($urandom);
      end
    end else if (!bus.req_a && $urandom_range(0, 3) == 0) begin
      bus.req_a  = 1'b1;
      bus.addr_a = randAddr();
      bus.data_a = DW'($urandom);
    end
    if (bus.gnt_b) begin
      if ($urandom_range(0, 2) == 0) bus.req_b = 1'b0;
      else begin
        bus.addr_b = randAddr();
        bus.data_b = DW'($urandom);
      end
    end else if (!bus.req_b && $urandom_range(0, 3) == 0) begin
      bus.req_b  = 1'b1;
      bus.addr_b = randAddr();
      bus.data_b = DW'($urandom);
    end
  endtask

  task automatic step(input int n, input bit agents);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (agents) applyStimulus();
    end
  endtask

  task automatic waitDone();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < CW + 10; i++) begin
      @(negedge clk);
      applyStimulus();
      if (bus.clr_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) timeoutSeen = 1'b1;
  endtask

  initial begin
    bit seen;
    rst           = 1'b0;
    zeroCheckCyc  = 1;
    bus.req_a     = 1'b0;
    bus.addr_a    = '0;
    bus.data_a    = '0;
    bus.req_b     = 1'b0;
    bus.addr_b    = '0;
    bus.data_b    = '0;
    bus.clr_start = 1'b0;
    bus.clr_color = '0;
    step(1, 0);
    rst = 1'b1;

    // Single request: one grant, then masked while req is still high.
    bus.req_a  = 1'b1;
    bus.addr_a = AW'(100);
    bus.data_a = 3'b100;
    step(2, 0);
    bus.req_a = 1'b0;
    step(2, 0);

    // Both held high from reset: A, B, A, B, A.
    rst          = 1'b0;
    zeroCheckCyc = cyc + 1;
    bus.req_a    = 1'b1;
    bus.addr_a   = AW'(1);
    bus.data_a   = 3'b001;
    bus.req_b    = 1'b1;
    bus.addr_b   = AW'(2);
    bus.data_b   = 3'b110;
    step(1, 0);
    rst = 1'b1;
    step(5, 0);
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    step(2, 0);

    // Out-of-range address: granted, flagged, not written.
    bus.req_a  = 1'b1;
    bus.addr_a = AW'(CW);
    bus.data_a = 3'b111;
    step(1, 0);
    bus.req_a = 1'b0;
    step(2, 0);

    // Random traffic from both requesters.
    step(3000, 1);

    // Full clear with traffic pending; B is guaranteed to be waiting.
    bus.clr_color = 3'b010;
    bus.clr_start = 1'b1;
    step(1, 1);
    bus.clr_start = 1'b0;
    step(10, 1);
    if (!bus.req_b) begin
      bus.req_b  = 1'b1;
      bus.addr_b = AW'(7);
      bus.data_b = 3'b011;
    end
    waitDone();
    step(20, 1);

    // Clear aborted by reset at address 5000, then restarted from 0.
    bus.clr_color = 3'b101;
    bus.clr_start = 1'b1;
    step(1, 1);
    bus.clr_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < CW + 10; i++) begin
      @(negedge clk);
      if (bus.mem_we && bus.mem_addr == AW'(5000)) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) timeoutSeen = 1'b1;
    rst          = 1'b0;
    zeroCheckCyc = cyc + 1;
    step(1, 0);
    rst = 1'b1;
    step(3, 1);
    bus.clr_color = 3'b001;
    bus.clr_start = 1'b1;
    step(1, 1);
    bus.clr_start = 1'b0;
    waitDone();
    step(30, 1);
    step(5, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
